// File: rtl/residue_adjust_sequencer.sv
`default_nettype none
// ============================================================================
// residue_adjust_sequencer : divider -> adjuster pass sequencer with residue
// feedback; optional watchdog via RESIDUE_ADJ_TIMEOUT_EN.   Rev 1.0
// ============================================================================
module residue_adjust_sequencer #(
    parameter int MAX_PASSES     = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    output logic             div_start,
    input  logic             div_done,
    output logic             adj_en,
    input  logic             adj_done,
    input  logic             cond1_in,
    input  logic             cond2_in,
    output logic             fb_sel,
    output logic             busy,
    output logic             done,
    output logic             zero_found,
    output logic [CNT_W-1:0] pass_count,
    output logic             overflow_err,
    output logic             timeout_err
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_DIV_ISSUE = 3'd1;
    localparam logic [2:0] S_DIV_WAIT  = 3'd2;
    localparam logic [2:0] S_ADJ_ISSUE = 3'd3;
    localparam logic [2:0] S_ADJ_WAIT  = 3'd4;
    localparam logic [2:0] S_EVAL      = 3'd5;
    localparam logic [2:0] S_FINISH    = 3'd6;

    localparam logic [CNT_W-1:0] C_MAX_PASSES = CNT_W'(MAX_PASSES);

    logic [2:0]       state_q, state_d;
    logic             div_start_q, div_start_d;
    logic             adj_en_q, adj_en_d;
    logic             fb_sel_q, fb_sel_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             zero_found_q, zero_found_d;
    logic [CNT_W-1:0] pass_count_q, pass_count_d;
    logic             overflow_err_q, overflow_err_d;
    logic             in_wait;
    logic             tmo_hit;
    logic             passes_left;

    assign in_wait     = (state_q == S_DIV_WAIT) || (state_q == S_ADJ_WAIT);
    assign passes_left = (pass_count_q < C_MAX_PASSES);

`ifdef RESIDUE_ADJ_TIMEOUT_EN
    localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt_q;
    logic             timeout_err_q;

    // Wait states are never entered back-to-back, so clearing outside them
    // is the same as clearing on entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_q <= '0;
        end else if (in_wait) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end else begin
            tmo_cnt_q <= '0;
        end
    end

    assign tmo_hit = in_wait && (tmo_cnt_q == TMO_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timeout_err_q <= 1'b0;
        end else if (state_q == S_IDLE && start) begin
            timeout_err_q <= 1'b0;
        end else if (in_wait && state_d == S_FINISH) begin
            timeout_err_q <= 1'b1;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;

    if (TIMEOUT_CYCLES < 1) begin : g_tmo_cfg_unused
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (start) state_d = S_DIV_ISSUE;
            S_DIV_ISSUE: state_d = S_DIV_WAIT;
            S_DIV_WAIT: begin
                if (div_done)     state_d = S_ADJ_ISSUE;
                else if (tmo_hit) state_d = S_FINISH;
            end
            S_ADJ_ISSUE: state_d = S_ADJ_WAIT;
            S_ADJ_WAIT: begin
                if (adj_done)     state_d = S_EVAL;
                else if (tmo_hit) state_d = S_FINISH;
            end
            S_EVAL: begin
                if (cond1_in && passes_left) state_d = S_ADJ_ISSUE;
                else                         state_d = S_FINISH;
            end
            S_FINISH:    state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs, decoded from the upcoming state.
    always_comb begin
        div_start_d    = (state_d == S_DIV_ISSUE);
        adj_en_d       = (state_d == S_ADJ_ISSUE);
        busy_d         = (state_d != S_IDLE);
        done_d         = (state_d == S_FINISH);
        fb_sel_d       = fb_sel_q;
        zero_found_d   = zero_found_q;
        pass_count_d   = pass_count_q;
        overflow_err_d = overflow_err_q;

        if (state_q == S_IDLE && start) begin
            fb_sel_d       = 1'b0;
            zero_found_d   = 1'b0;
            pass_count_d   = '0;
            overflow_err_d = 1'b0;
        end

        if (state_d == S_ADJ_ISSUE && passes_left) begin
            pass_count_d = pass_count_q + 1'b1;
        end

        if (state_q == S_EVAL) begin
            zero_found_d = zero_found_q | cond2_in;
            if (cond1_in && passes_left) begin
                fb_sel_d = 1'b1;
            end else if (cond1_in) begin
                overflow_err_d = 1'b1;
            end
        end

        if (state_q == S_FINISH) begin
            fb_sel_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_start_q    <= 1'b0;
            adj_en_q       <= 1'b0;
            fb_sel_q       <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            zero_found_q   <= 1'b0;
            pass_count_q   <= '0;
            overflow_err_q <= 1'b0;
        end else begin
            div_start_q    <= div_start_d;
            adj_en_q       <= adj_en_d;
            fb_sel_q       <= fb_sel_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            zero_found_q   <= zero_found_d;
            pass_count_q   <= pass_count_d;
            overflow_err_q <= overflow_err_d;
        end
    end

    assign div_start    = div_start_q;
    assign adj_en       = adj_en_q;
    assign fb_sel       = fb_sel_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign zero_found   = zero_found_q;
    assign pass_count   = pass_count_q;
    assign overflow_err = overflow_err_q;

endmodule
`default_nettype wire

// File: tb/tb_residue_adjust_sequencer.sv
`default_nettype none
// ============================================================================
// tb_residue_adjust_sequencer : randomized bench with an operation-level model
// of the pass sequencer. Rev 1.0
// ============================================================================
module tb_residue_adjust_sequencer;

    localparam int MAXP = 4;
    localparam int TMO  = 16;
    localparam int CW   = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          div_done = 1'b0;
    logic          adj_done = 1'b0;
    logic          cond1_in = 1'b0;
    logic          cond2_in = 1'b0;
    logic          div_start, adj_en, fb_sel, busy, done;
    logic          zero_found, overflow_err, timeout_err;
    logic [CW-1:0] pass_count;

    int tests_run    = 0;
    int tests_failed = 0;

    bit c1 [1:16];
    bit c2 [1:16];
    int alat [1:16];

    typedef struct packed {
        logic [7:0]  n_div;
        logic [7:0]  n_adj;
        logic [7:0]  n_done;
        logic [15:0] done_cyc;
        logic [3:0]  pcnt;
        logic        zero;
        logic        ovf;
        logic        tmo;
        logic [16:0] fb_mask;
        logic        fb_after;
        logic [7:0]  busy_err;
    } op_t;

    residue_adjust_sequencer #(
        .MAX_PASSES     (MAXP),
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (CW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .div_start    (div_start),
        .div_done     (div_done),
        .adj_en       (adj_en),
        .adj_done     (adj_done),
        .cond1_in     (cond1_in),
        .cond2_in     (cond2_in),
        .fb_sel       (fb_sel),
        .busy         (busy),
        .done         (done),
        .zero_found   (zero_found),
        .pass_count   (pass_count),
        .overflow_err (overflow_err),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    // Operation-level expectation: passes run until cond1 clears or the limit
    // is hit; latency is the sum of state dwell times plus responder delays.
    function automatic op_t model_op(input int dlat, input bit stall);
        op_t m;
        int  sum;
        m   = '0;
        sum = 0;
        m.n_div = 8'd1;
        if (stall) begin
`ifdef RESIDUE_ADJ_TIMEOUT_EN
            m.n_done   = 8'd1;
            m.tmo      = 1'b1;
            m.done_cyc = 16'(2 + TMO);
`endif
            return m;
        end
        m.n_done = 8'd1;
        for (int k = 1; k <= MAXP; k++) begin
            m.n_adj = 8'(k);
            m.pcnt  = 4'(k);
            sum    += alat[k];
            m.zero  = m.zero | c2[k];
            if (k > 1) m.fb_mask[k] = 1'b1;
            if (!c1[k]) break;
            if (k == MAXP) m.ovf = 1'b1;
        end
        m.done_cyc = 16'(3 + dlat + 3 * int'(m.n_adj) + sum);
        return m;
    endfunction

    // Plays the divider/adjuster and records what the sequencer did.
    task automatic run_op(input int dlat, input bit stall, input bit hold_start,
                          input bit spurious, input int budget, output op_t o);
        int cyc, dpend, apend, apass, after, hold;
        bit div_delivered;
        o = '0;
        cyc = 0; dpend = 0; apend = 0; apass = 0; after = 0; hold = 0;
        div_delivered = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        while (cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
            if (done === 1'b1) begin
                o.n_done++;
                if (o.done_cyc == 0) o.done_cyc = 16'(cyc);
            end
            if (busy !== (o.done_cyc == 0 || cyc == int'(o.done_cyc))) o.busy_err++;
            div_done = 1'b0;
            adj_done = 1'b0;
            if (dpend > 0) begin
                dpend--;
                if (dpend == 0 && !stall) begin
                    div_done      = 1'b1;
                    div_delivered = 1'b1;
                end
            end
            if (hold > 0) begin
                hold--;
            end else begin
                cond1_in = 1'($urandom_range(0, 1));
                cond2_in = 1'($urandom_range(0, 1));
            end
            if (apend > 0) begin
                apend--;
                if (apend == 0) begin
                    adj_done = 1'b1;
                    cond1_in = (apass >= 1 && apass <= 16) ? c1[apass] : 1'b0;
                    cond2_in = (apass >= 1 && apass <= 16) ? c2[apass] : 1'b0;
                    hold     = 1;
                end
            end
            if (spurious && o.done_cyc == 0) begin
                if (div_delivered && !div_done) div_done = 1'($urandom_range(0, 1));
                if (o.n_adj == 0 && !adj_done)  adj_done = 1'($urandom_range(0, 1));
            end
            if (div_start === 1'b1) begin
                o.n_div++;
                dpend = dlat + 1;
            end
            if (adj_en === 1'b1) begin
                o.n_adj++;
                apass = int'(o.n_adj);
                if (apass <= 16 && fb_sel === 1'b1) o.fb_mask[apass] = 1'b1;
                apend = ((apass >= 1 && apass <= 16) ? alat[apass] : 0) + 1;
            end
            start = (hold_start && o.done_cyc == 0) ? 1'b1 : 1'b0;
            if (o.done_cyc != 0) begin
                after++;
                if (after == 4) break;
            end
        end
        o.fb_after = fb_sel;
        o.pcnt     = pass_count;
        o.zero     = zero_found;
        o.ovf      = overflow_err;
        o.tmo      = timeout_err;
        start    = 1'b0;
        div_done = 1'b0;
        adj_done = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({div_start, adj_en, fb_sel, busy, done, zero_found, pass_count, overflow_err, timeout_err} !== 13'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got %b required all zero",
                     {div_start, adj_en, fb_sel, busy, done, zero_found, pass_count, overflow_err, timeout_err});
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if ({busy, done, div_start} !== 3'b000) begin
            tests_failed++;
            $display("FAIL idle_after_release: got busy/done/div_start=%b required 000", {busy, done, div_start});
        end
    endtask

    task automatic test_reset_mid_op;
        op_t o, e;
        bit  done_seen;
        c1[1] = 1'b0; c2[1] = 1'b0; alat[1] = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 div_done = 1'b1;
        @(posedge clk); #1 div_done = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if ({busy, pass_count} !== {1'b1, 4'd1}) begin
            tests_failed++;
            $display("FAIL mid_op_reached: got busy=%b pass_count=%0d required 1 and 1", busy, pass_count);
        end
        #2 reset_n = 1'b0;
        #1;
        tests_run++;
        if ({div_start, adj_en, fb_sel, busy, done, zero_found, pass_count, overflow_err, timeout_err} !== 13'd0) begin
            tests_failed++;
            $display("FAIL async_reset_outputs: got %b required all zero",
                     {div_start, adj_en, fb_sel, busy, done, zero_found, pass_count, overflow_err, timeout_err});
        end
        done_seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done === 1'b1) done_seen = 1'b1;
        end
        reset_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) done_seen = 1'b1;
        end
        tests_run++;
        if (done_seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_abort_no_done: got done/busy activity=%b required 0", done_seen);
        end
        c1[1] = 1'b1; c1[2] = 1'b0; c2[1] = 1'b0; c2[2] = 1'b0; alat[1] = 1; alat[2] = 0;
        e = model_op(2, 1'b0);
        run_op(2, 1'b0, 1'b0, 1'b0, 200, o);
        tests_run++;
        if (o !== e) begin
            tests_failed++;
            $display("FAIL op_after_reset: got %p required %p", o, e);
        end
    endtask

    task automatic test_single_pass;
        op_t o, e;
        c1[1] = 1'b0; c2[1] = 1'b1; alat[1] = 2;
        e = model_op(5, 1'b0);
        run_op(5, 1'b0, 1'b0, 1'b0, 200, o);
        tests_run++;
        if (o !== e) begin
            tests_failed++;
            $display("FAIL single_pass: got %p required %p", o, e);
        end
    endtask

    task automatic test_two_pass;
        op_t o, e;
        c1[1] = 1'b1; c1[2] = 1'b0; c2[1] = 1'b0; c2[2] = 1'b0; alat[1] = 1; alat[2] = 3;
        e = model_op(1, 1'b0);
        run_op(1, 1'b0, 1'b0, 1'b0, 200, o);
        tests_run++;
        if (o !== e) begin
            tests_failed++;
            $display("FAIL two_pass: got %p required %p", o, e);
        end
    endtask

    task automatic test_overflow;
        op_t o, e;
        for (int k = 1; k <= 16; k++) begin
            c1[k] = 1'b1; c2[k] = 1'b0; alat[k] = k % 3;
        end
        c2[3] = 1'b1;
        e = model_op(0, 1'b0);
        run_op(0, 1'b0, 1'b0, 1'b0, 200, o);
        tests_run++;
        if (o !== e) begin
            tests_failed++;
            $display("FAIL overflow: got %p required %p", o, e);
        end
        tests_run++;
        if ({o.ovf, o.pcnt, o.n_adj} !== {1'b1, 4'd4, 8'd4}) begin
            tests_failed++;
            $display("FAIL overflow_limit: got ovf=%b passes=%0d adj_en=%0d required 1 4 4", o.ovf, o.pcnt, o.n_adj);
        end
    endtask

    task automatic test_min_latency;
        op_t o, e;
        c1[1] = 1'b0; c2[1] = 1'b0; alat[1] = 0;
        e = model_op(0, 1'b0);
        run_op(0, 1'b0, 1'b0, 1'b0, 200, o);
        tests_run++;
        if (o !== e) begin
            tests_failed++;
            $display("FAIL min_latency_op: got %p required %p", o, e);
        end
        tests_run++;
        if (o.done_cyc !== 16'd6) begin
            tests_failed++;
            $display("FAIL min_latency: got done at cycle %0d required 6", o.done_cyc);
        end
    endtask

    task automatic test_back_to_back;
        op_t o, e;
        for (int i = 0; i < 4; i++) begin
            for (int k = 1; k <= 16; k++) begin
                c1[k]   = ($urandom_range(0, 2) != 0);
                c2[k]   = 1'($urandom_range(0, 1));
                alat[k] = int'($urandom_range(0, 4));
            end
            e = model_op(3, 1'b0);
            run_op(3, 1'b0, 1'b1, 1'b1, 200, o);
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL start_held_spurious[%0d]: got %p required %p", i, o, e);
            end
        end
    endtask

    task automatic test_random;
        op_t o, e;
        int  dl;
        for (int i = 0; i < 25; i++) begin
            for (int k = 1; k <= 16; k++) begin
                c1[k]   = ($urandom_range(0, 2) != 0);
                c2[k]   = ($urandom_range(0, 3) == 0);
                alat[k] = int'($urandom_range(0, 5));
            end
            dl = int'($urandom_range(0, 6));
            e  = model_op(dl, 1'b0);
            run_op(dl, 1'b0, 1'b0, 1'b0, 200, o);
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL random_op[%0d]: got %p required %p", i, o, e);
            end
        end
    endtask

    task automatic test_stall;
        op_t o, e;
        e = model_op(0, 1'b1);
        run_op(0, 1'b1, 1'b0, 1'b0, 60, o);
        tests_run++;
        if (o !== e) begin
            tests_failed++;
            $display("FAIL div_stall: got %p required %p", o, e);
        end
        @(posedge clk); #1 reset_n = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
        c1[1] = 1'b0; c2[1] = 1'b1; alat[1] = 1;
        e = model_op(1, 1'b0);
        run_op(1, 1'b0, 1'b0, 1'b0, 200, o);
        tests_run++;
        if (o !== e) begin
            tests_failed++;
            $display("FAIL op_after_stall: got %p required %p", o, e);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_op();
        test_single_pass();
        test_two_pass();
        test_overflow();
        test_min_latency();
        test_back_to_back();
        test_random();
        test_stall();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/residue_adjust_sequencer.md
Name: residue_adjust_sequencer

Overview:
- Control FSM that sequences one reduction pass: parallel divider, then the 12-row result adjuster, then feedback of adjusted residues.
- Repeats adjust passes while any residue is still negative (adjuster condition1), up to MAX_PASSES.
- Reports completion, pass count, zero-residue detection (condition2) and error status to the top-level controller.
- Sits between the top-level controller and the divider/adjuster pair; contains no datapath registers.

Parameters:
- MAX_PASSES, 4: maximum adjust passes per operation; range 1..15.
- TIMEOUT_CYCLES, 1024: watchdog limit while waiting for div_done or adj_done; only used with the optional feature.
- CNT_W, 4: width of pass_count; must hold MAX_PASSES.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  1-cycle request; accepted only in IDLE, ignored otherwise.
- div_start  out  1  1-cycle pulse to the parallel divider.
- div_done  in  1  divider completion pulse.
- adj_en  out  1  1-cycle enable pulse to the adjuster.
- adj_done  in  1  adjuster completion pulse.
- cond1_in  in  1  adjuster condition1 (any row negative); sampled only in EVAL.
- cond2_in  in  1  adjuster condition2 (any row zero); sampled only in EVAL.
- fb_sel  out  1  1 = adjuster inputs taken from the adjuster's registered outputs; 0 = from divider remainders.
- busy  out  1  high in every state except IDLE.
- done  out  1  1-cycle pulse on completion, success or error.
- zero_found  out  1  sticky OR of cond2_in over all passes of the current operation.
- pass_count  out  CNT_W  number of adj_en pulses issued in the current operation.
- overflow_err  out  1  last pass still reported cond1 after MAX_PASSES.
- timeout_err  out  1  watchdog expired.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; every output 0, including div_start, adj_en, fb_sel, busy, done, zero_found, pass_count, overflow_err, timeout_err. Reset mid-operation aborts immediately with no done pulse.
- All outputs registered. States: IDLE, DIV_ISSUE, DIV_WAIT, ADJ_ISSUE, ADJ_WAIT, EVAL, FINISH.
- IDLE, start=1:
  - clear zero_found, pass_count, overflow_err, timeout_err and fb_sel;
  - go to DIV_ISSUE.
  - start in any other state is ignored; no queuing.
- DIV_ISSUE: assert div_start for exactly one cycle; go to DIV_WAIT.
- DIV_WAIT: on div_done go to ADJ_ISSUE. div_done in any other state is ignored.
- ADJ_ISSUE: assert adj_en for exactly one cycle; increment pass_count (saturating at MAX_PASSES); go to ADJ_WAIT.
- ADJ_WAIT: on adj_done go to EVAL. adj_done in any other state is ignored.
- EVAL (one cycle; samples cond1_in and cond2_in):
  - zero_found <= zero_found | cond2_in.
  - cond1_in=0: go to FINISH.
  - cond1_in=1 and pass_count < MAX_PASSES: fb_sel <= 1; go to ADJ_ISSUE. The divider is not restarted.
  - cond1_in=1 and pass_count == MAX_PASSES: overflow_err <= 1; go to FINISH.
- FINISH: done=1 for one cycle; go to IDLE.
  - fb_sel is cleared on the FINISH-to-IDLE transition.
  - zero_found, pass_count and both error flags hold until the next accepted start.
- div_done and adj_done asserted in the same cycle: only the one matching the current wait state is acted on.
- Minimum latency, start accepted to done, with zero-cycle div/adj responses and one pass: start(IDLE) -> DIV_ISSUE -> DIV_WAIT -> ADJ_ISSUE -> ADJ_WAIT -> EVAL -> FINISH, so done is high 6 cycles after the start edge.
- Each additional pass adds 3 cycles (ADJ_ISSUE, ADJ_WAIT, EVAL) plus the adjuster's own latency.

Optional Feature:
- Macro: RESIDUE_ADJ_TIMEOUT_EN.
- Defined:
  - a counter of width clog2(TIMEOUT_CYCLES+1) clears on entry to DIV_WAIT or ADJ_WAIT and counts each cycle spent in those states;
  - on reaching TIMEOUT_CYCLES without the expected done: timeout_err <= 1; go to FINISH (done pulses).
- Not defined: no counter logic; timeout_err is tied to 0; the FSM waits indefinitely.

Test Plan:
- Reset mid-ADJ_WAIT, then release: all outputs 0, state IDLE, no done pulse; next start proceeds normally.
- start; div_done after 5 cycles; adj_done after 2; cond1=0, cond2=1 -> exactly one div_start and one adj_en pulse; done pulses once; pass_count=1, zero_found=1, overflow_err=0, fb_sel=0 after done.
- cond1=1 on pass 1, cond1=0 on pass 2 -> two adj_en pulses, one div_start, fb_sel=1 during pass 2; pass_count=2, overflow_err=0.
- MAX_PASSES=4, cond1 always 1 -> four adj_en pulses; overflow_err=1; done once; pass_count=4.
- start held high during busy, plus spurious div_done in ADJ_WAIT -> no restart, no state change; single done.
- RESIDUE_ADJ_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, div_done never arrives -> timeout_err=1 and done pulses 16 cycles after DIV_WAIT entry. Same bench with the macro undefined -> busy stays 1, no done.
